// File: rtl/instr_packer.sv
// Packs an RV32I instruction stream into 32-bit memory words, compressing a
// small set of instructions to 16-bit RVC parcels and carrying half-words across words.
module instr_packer #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_instr,
  input  logic        flush_req,
  output logic        flush_done,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_word,
  output logic [31:0] out_addr,
  output logic [15:0] comp_cnt
);

  typedef enum logic {EMPTY, HALF} state_t;

  state_t      state_q, state_d;
  logic [15:0] hold_q, hold_d;
  logic        out_valid_q, out_valid_d;
  logic [31:0] out_word_q, out_word_d;
  logic [31:0] out_addr_q, out_addr_d;
  logic [15:0] comp_cnt_q, comp_cnt_d;
  logic        flush_done_q, flush_done_d;

  logic [6:0]  opcode;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic        is_addi, is_add, imm_small, imm_nz;
  logic        is_comp;
  logic [15:0] cparcel;
  logic        accept, do_flush, hs, emit;
  logic [31:0] emit_word;

  // Parcels are stored little-endian: low byte at the lower address.
  function automatic logic [15:0] swap(input logic [15:0] p);
    return {p[7:0], p[15:8]};
  endfunction

  assign opcode = in_instr[6:0];
  assign rd     = in_instr[11:7];
  assign funct3 = in_instr[14:12];
  assign rs1    = in_instr[19:15];
  assign rs2    = in_instr[24:20];
  assign funct7 = in_instr[31:25];

  assign is_addi   = (opcode == 7'b0010011) && (funct3 == 3'b000);
  assign is_add    = (opcode == 7'b0110011) && (funct3 == 3'b000) && (funct7 == 7'b0);
  // A 12-bit immediate fits in 6 signed bits when bits [11:5] all agree.
  assign imm_small = (&in_instr[31:25]) || !(|in_instr[31:25]);
  assign imm_nz    = |in_instr[31:20];

  always_comb begin
    is_comp = 1'b0;
    cparcel = 16'h0000;
    if (in_instr == 32'h0000_0013) begin
      is_comp = 1'b1;
      cparcel = 16'h0001;
    end else if (is_addi && imm_small && imm_nz && rd != 5'd0 && rd == rs1) begin
      is_comp = 1'b1;
      cparcel = {3'b000, in_instr[25], rd, in_instr[24:20], 2'b01};
    end else if (is_addi && imm_small && rs1 == 5'd0 && rd != 5'd0) begin
      is_comp = 1'b1;
      cparcel = {3'b010, in_instr[25], rd, in_instr[24:20], 2'b01};
    end else if (is_add && rs1 == 5'd0 && rd != 5'd0 && rs2 != 5'd0) begin
      is_comp = 1'b1;
      cparcel = {4'b1000, rd, rs2, 2'b10};
    end else if (is_add && rd == rs1 && rd != 5'd0 && rs2 != 5'd0) begin
      is_comp = 1'b1;
      cparcel = {4'b1001, rd, rs2, 2'b10};
    end
  end

  assign in_ready = !out_valid_q || out_ready;
  assign accept   = in_valid && in_ready;
  assign do_flush = flush_req && !in_valid && in_ready;
  assign hs       = out_valid_q && out_ready;

  always_comb begin
    state_d      = state_q;
    hold_d       = hold_q;
    out_valid_d  = hs ? 1'b0 : out_valid_q;
    out_word_d   = out_word_q;
    out_addr_d   = hs ? out_addr_q + 32'd4 : out_addr_q;
    comp_cnt_d   = comp_cnt_q;
    flush_done_d = 1'b0;
    emit         = 1'b0;
    emit_word    = 32'h0;
    if (accept) begin
      if (is_comp) begin
        comp_cnt_d = comp_cnt_q + 16'd1;
        if (state_q == EMPTY) begin
          hold_d  = cparcel;
          state_d = HALF;
        end else begin
          emit      = 1'b1;
          emit_word = {swap(hold_q), swap(cparcel)};
          state_d   = EMPTY;
        end
      end else if (state_q == EMPTY) begin
        emit      = 1'b1;
        emit_word = {swap(in_instr[15:0]), swap(in_instr[31:16])};
      end else begin
        emit      = 1'b1;
        emit_word = {swap(hold_q), swap(in_instr[15:0])};
        hold_d    = in_instr[31:16];
      end
    end else if (do_flush) begin
      flush_done_d = 1'b1;
      if (state_q == HALF) begin
        // Pad the trailing half-word with C.NOP so the word stays executable.
        emit      = 1'b1;
        emit_word = {swap(hold_q), swap(16'h0001)};
        state_d   = EMPTY;
      end
    end
    if (emit) begin
      out_valid_d = 1'b1;
      out_word_d  = emit_word;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= EMPTY;
      hold_q       <= 16'h0000;
      out_valid_q  <= 1'b0;
      out_word_q   <= 32'h0;
      out_addr_q   <= BASE_ADDR;
      comp_cnt_q   <= 16'h0000;
      flush_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      hold_q       <= hold_d;
      out_valid_q  <= out_valid_d;
      out_word_q   <= out_word_d;
      out_addr_q   <= out_addr_d;
      comp_cnt_q   <= comp_cnt_d;
      flush_done_q <= flush_done_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_word   = out_word_q;
  assign out_addr   = out_addr_q;
  assign comp_cnt   = comp_cnt_q;
  assign flush_done = flush_done_q;

endmodule

// File: tb/tb_instr_packer.sv
// Directed bench for instr_packer; expected words are queued when driven and
// checked by a monitor on each output handshake.
module tb_instr_packer;
  localparam logic [31:0] BASE = 32'h1000_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_instr = 32'h0;
  logic        flush_req = 1'b0;
  logic        flush_done;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_word;
  logic [31:0] out_addr;
  logic [15:0] comp_cnt;

  int checks = 0;
  int failures = 0;
  int fd_cnt = 0;
  logic [31:0] exp_addr = BASE;
  logic [63:0] sb[$];

  instr_packer #(.BASE_ADDR(BASE)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .flush_req(flush_req), .flush_done(flush_done),
    .out_valid(out_valid), .out_ready(out_ready), .out_word(out_word),
    .out_addr(out_addr), .comp_cnt(comp_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [31:0] w);
    sb.push_back({w, exp_addr});
    exp_addr = exp_addr + 32'd4;
  endtask

  always @(negedge clk) begin
    if (rst_n && flush_done) fd_cnt++;
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        chk("unexpected_word", out_word, 32'hxxxx_xxxx);
      end else begin
        logic [63:0] e;
        e = sb.pop_front();
        chk("sb_word", out_word, e[63:32]);
        chk("sb_addr", out_addr, e[31:0]);
      end
    end
  end

  // Returns at posedge+1 right after the accepting edge.
  task automatic send(input logic [31:0] ins);
    int n;
    n = 0;
    in_instr = ins;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) chk("send_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
    chk("rst_out_addr", out_addr, BASE);
    chk("rst_comp_cnt", {16'b0, comp_cnt}, 32'd0);
    chk("rst_out_word", out_word, 32'd0);
    rst_n = 1'b1;
    idle(2);
    chk("idle_out_valid", {31'b0, out_valid}, 32'd0);
    chk("idle_flush_done", {31'b0, flush_done}, 32'd0);

    // plain 32-bit LW
    out_ready = 1'b1;
    push(32'h8320_0100);
    send(32'h0001_2083);
    chk("lw_valid", {31'b0, out_valid}, 32'd1);
    chk("lw_addr", out_addr, BASE);
    idle(1);
    chk("lw_addr_next", out_addr, BASE + 32'd4);
    chk("lw_drained", {31'b0, out_valid}, 32'd0);

    // C.LI then C.NOP share one word
    send(32'h0050_0093);
    chk("cli_no_emit", {31'b0, out_valid}, 32'd0);
    push(32'h9540_0100);
    send(32'h0000_0013);
    chk("pair_valid", {31'b0, out_valid}, 32'd1);
    chk("pair_comp_cnt", {16'b0, comp_cnt}, 32'd2);
    idle(1);

    // C.ADD, straddling LW, then flush pads with C.NOP
    push(32'h2694_8320);
    push(32'h0100_0100);
    fd_cnt = 0;
    send(32'h0094_0433);
    send(32'h0001_2083);
    flush_req = 1'b1;
    @(posedge clk); #1;
    flush_req = 1'b0;
    chk("flush_done_pulse", {31'b0, flush_done}, 32'd1);
    idle(4);
    chk("flush_done_once", fd_cnt, 32'd1);
    chk("flush_comp_cnt", {16'b0, comp_cnt}, 32'd3);

    // back-pressure holds the word stable
    out_ready = 1'b0;
    push(32'h8320_0100);
    send(32'h0001_2083);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall_in_ready", {31'b0, in_ready}, 32'd0);
      chk("stall_valid", {31'b0, out_valid}, 32'd1);
      chk("stall_word", out_word, 32'h8320_0100);
      chk("stall_addr", out_addr, exp_addr - 32'd4);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("stall_one_hs", {31'b0, out_valid}, 32'd0);
    chk("stall_addr_after", out_addr, exp_addr);

    // ADDI with out-of-range immediate stays 32-bit
    push(32'h9380_0002);
    send(32'h0200_8093);
    chk("addi32_comp_cnt", {16'b0, comp_cnt}, 32'd3);
    idle(1);

    // C.MV + C.ADDI(-1), ADDI with rd=x0 stays 32-bit
    push(32'h8A80_FD10);
    send(32'h0020_00b3);
    send(32'hfff0_8093);
    chk("mv_addi_comp_cnt", {16'b0, comp_cnt}, 32'd5);
    push(32'h1380_5000);
    send(32'h0050_8013);
    chk("rd0_comp_cnt", {16'b0, comp_cnt}, 32'd5);
    idle(1);

    // flush while empty: pulse only
    fd_cnt = 0;
    flush_req = 1'b1;
    @(posedge clk); #1;
    flush_req = 1'b0;
    chk("flush_empty_no_word", {31'b0, out_valid}, 32'd0);
    idle(2);
    chk("flush_empty_pulse", fd_cnt, 32'd1);

    // reset with a pending parcel discards it
    send(32'h0000_0013);
    idle(1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", {31'b0, out_valid}, 32'd0);
    chk("mid_rst_addr", out_addr, BASE);
    chk("mid_rst_comp_cnt", {16'b0, comp_cnt}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    exp_addr = BASE;
    @(posedge clk); #1;
    push(32'h8320_0100);
    send(32'h0001_2083);
    chk("post_rst_addr", out_addr, BASE);

    begin
      int n;
      n = 0;
      while (sb.size() != 0 && n < 100) begin
        @(posedge clk); #1;
        n++;
      end
    end
    chk("sb_empty", sb.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
